digit_counter: RTL and testbench

DIGIT_COUNTER -- requirements
Module: digit_counter

---
 rtl/digit_counter_if.sv | 24 ++
 rtl/digit_counter.sv | 141 ++++++++++++++
 tb/tb_digit_counter.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/digit_counter_if.sv
// Control and display bundle of the two-digit BCD counter.
// start/stop are edge-detected requests; clear and up are levels sampled on every clock edge.
interface digit_counter_if;
    logic       start;
    logic       stop;
    logic       clear;
    logic       up;
    logic [3:0] ones;
    logic [3:0] tens;
    logic       blank_tens;
    logic       tc;
    logic       running;
    logic       state_dbg;

    modport master (
        output start, stop, clear, up,
        input  ones, tens, blank_tens, tc, running, state_dbg
    );

    modport slave (
        input  start, stop, clear, up,
        output ones, tens, blank_tens, tc, running, state_dbg
    );
endinterface

// File: rtl/digit_counter.sv
// Two-digit BCD up/down counter stepped by a prescaler, with a start/stop run FSM.
// The count wraps between 00 and MAXVAL in either direction.
module digit_counter #(
    parameter int DIV    = 4,
    parameter int MAXVAL = 99
) (
    input  logic           clk,
    input  logic           rst,
    digit_counter_if.slave bus
);
    localparam int              PW      = $clog2(DIV);
    localparam logic [PW-1:0]   PS_LAST = PW'(DIV - 1);
    localparam logic [3:0]      MAX_T   = 4'(MAXVAL / 10);
    localparam logic [3:0]      MAX_O   = 4'(MAXVAL % 10);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state;
    state_t        state_n;
    logic          start_q;
    logic          stop_q;
    logic          start_arm;
    logic          start_edge;
    logic          stop_edge;
    logic [PW-1:0] ps;
    logic [PW-1:0] ps_n;
    logic          tick;
    logic [3:0]    ones;
    logic [3:0]    tens;
    logic [3:0]    ones_n;
    logic [3:0]    tens_n;
    logic          at_max;
    logic          at_zero;

    // start_arm stays low until start has been seen low once after reset,
    // so a start held high through reset cannot look like a fresh edge.
    assign start_edge = bus.start & ~start_q & start_arm;
    assign stop_edge  = bus.stop & ~stop_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_q   <= 1'b0;
            stop_q    <= 1'b0;
            start_arm <= 1'b0;
        end else begin
            start_q   <= bus.start;
            stop_q    <= bus.stop;
            start_arm <= start_arm | ~bus.start;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // A stop edge always wins, including when it arrives alongside a start edge.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start_edge && !stop_edge) state_n = RUN;
            RUN:     if (stop_edge) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign tick = (state == RUN) && (ps == PS_LAST);

    // The prescaler only advances while the run continues past this edge.
    always_comb begin
        ps_n = '0;
        if (!bus.clear && (state == RUN) && (state_n == RUN)) begin
            ps_n = tick ? '0 : ps + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ps <= '0;
        end else begin
            ps <= ps_n;
        end
    end

    assign at_max  = (tens == MAX_T) && (ones == MAX_O);
    assign at_zero = (tens == 4'd0) && (ones == 4'd0);

    always_comb begin
        ones_n = ones;
        tens_n = tens;
        if (bus.clear) begin
            ones_n = 4'd0;
            tens_n = 4'd0;
        end else if (tick) begin
            if (bus.up) begin
                if (at_max) begin
                    ones_n = 4'd0;
                    tens_n = 4'd0;
                end else if (ones == 4'd9) begin
                    ones_n = 4'd0;
                    tens_n = tens + 4'd1;
                end else begin
                    ones_n = ones + 4'd1;
                end
            end else begin
                if (at_zero) begin
                    ones_n = MAX_O;
                    tens_n = MAX_T;
                end else if (ones == 4'd0) begin
                    ones_n = 4'd9;
                    tens_n = tens - 4'd1;
                end else begin
                    ones_n = ones - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ones <= 4'd0;
            tens <= 4'd0;
        end else begin
            ones <= ones_n;
            tens <= tens_n;
        end
    end

    assign bus.ones       = ones;
    assign bus.tens       = tens;
    assign bus.blank_tens = (tens == 4'd0);
    assign bus.running    = (state == RUN);
    assign bus.tc         = (state == RUN) && (bus.up ? at_max : at_zero);
    assign bus.state_dbg  = state;
endmodule

// File: tb/tb_digit_counter.sv
// Bench for digit_counter: two instances (DIV=4/MAXVAL=99 and DIV=2/MAXVAL=23) share stimulus
// and are compared every cycle against an integer-count reference model.
module tb_digit_counter;
    localparam int DIV_A = 4;
    localparam int MAX_A = 99;
    localparam int DIV_B = 2;
    localparam int MAX_B = 23;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic start = 1'b0;
    logic stop  = 1'b0;
    logic clear = 1'b0;
    logic up    = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    digit_counter_if ifa ();
    digit_counter_if ifb ();

    assign ifa.start = start;
    assign ifa.stop  = stop;
    assign ifa.clear = clear;
    assign ifa.up    = up;
    assign ifb.start = start;
    assign ifb.stop  = stop;
    assign ifb.clear = clear;
    assign ifb.up    = up;

    digit_counter #(.DIV(DIV_A), .MAXVAL(MAX_A)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    digit_counter #(.DIV(DIV_B), .MAXVAL(MAX_B)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int m_cnt[2];
    int m_ph[2];
    bit m_run[2];
    bit m_arm[2];
    bit m_pst[2];
    bit m_pstp[2];
    int m_div[2] = '{DIV_A, DIV_B};
    int m_max[2] = '{MAX_A, MAX_B};

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_cnt[i]  = 0;
            m_ph[i]   = 0;
            m_run[i]  = 1'b0;
            m_arm[i]  = 1'b0;
            m_pst[i]  = 1'b0;
            m_pstp[i] = 1'b0;
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            bit sedge, tedge, tick, nrun;
            sedge = start && !m_pst[i] && m_arm[i];
            tedge = stop && !m_pstp[i];
            tick  = m_run[i] && (m_ph[i] == m_div[i] - 1);
            nrun  = tedge ? 1'b0 : (sedge ? 1'b1 : m_run[i]);
            if (clear)
                m_cnt[i] = 0;
            else if (tick && up)
                m_cnt[i] = (m_cnt[i] == m_max[i]) ? 0 : m_cnt[i] + 1;
            else if (tick)
                m_cnt[i] = (m_cnt[i] == 0) ? m_max[i] : m_cnt[i] - 1;
            if (clear || !(m_run[i] && nrun))
                m_ph[i] = 0;
            else
                m_ph[i] = (m_ph[i] + 1) % m_div[i];
            m_arm[i]  = m_arm[i] | !start;
            m_pst[i]  = start;
            m_pstp[i] = stop;
            m_run[i]  = nrun;
        end
    endtask

    function automatic int m_tc(int i);
        return (m_run[i] && (up ? (m_cnt[i] == m_max[i]) : (m_cnt[i] == 0))) ? 1 : 0;
    endfunction

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_inst(input string tag, input logic [3:0] o, input logic [3:0] t,
                              input logic bl, input logic tcv, input logic rn, input int i);
        chk({tag, ".ones"},       int'(o),   m_cnt[i] % 10);
        chk({tag, ".tens"},       int'(t),   m_cnt[i] / 10);
        chk({tag, ".blank_tens"}, int'(bl),  (m_cnt[i] < 10) ? 1 : 0);
        chk({tag, ".tc"},         int'(tcv), m_tc(i));
        chk({tag, ".running"},    int'(rn),  m_run[i] ? 1 : 0);
    endtask

    task automatic check_all();
        check_inst("a", ifa.ones, ifa.tens, ifa.blank_tens, ifa.tc, ifa.running, 0);
        check_inst("b", ifb.ones, ifb.tens, ifb.blank_tens, ifb.tc, ifb.running, 1);
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic wait_count(input int target, input int budget);
        int k;
        k = 0;
        while (m_cnt[0] != target && k < budget) begin
            step();
            k++;
        end
        chk($sformatf("reach_count_%0d", target), int'(ifa.tens) * 10 + int'(ifa.ones), target);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".a.ones"},    int'(ifa.ones),       0);
        chk({tag, ".a.tens"},    int'(ifa.tens),       0);
        chk({tag, ".a.running"}, int'(ifa.running),    0);
        chk({tag, ".a.blank"},   int'(ifa.blank_tens), 1);
        chk({tag, ".a.tc"},      int'(ifa.tc),         0);
        chk({tag, ".b.ones"},    int'(ifb.ones),       0);
        chk({tag, ".b.running"}, int'(ifb.running),    0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       start;
        logic       stop;
        logic       clear;
        logic       up;
        logic [3:0] e_ones;
        logic [3:0] e_tens;
        logic       e_run;
        logic       e_tc;
    } vec_t;

    vec_t tbl[10];

    function automatic vec_t mk(logic s, logic [3:0] o, logic r);
        vec_t v;
        v.start  = s;
        v.stop   = 1'b0;
        v.clear  = 1'b0;
        v.up     = 1'b1;
        v.e_ones = o;
        v.e_tens = 4'd0;
        v.e_run  = r;
        v.e_tc   = 1'b0;
        return v;
    endfunction

    initial begin
        #1_000_000;
        n_errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        int frozen;
        // start pulse at edge N (row 1): first step at N+4 (row 5), second at N+8 (row 9)
        tbl[0] = mk(1'b0, 4'd0, 1'b0);
        tbl[1] = mk(1'b1, 4'd0, 1'b1);
        tbl[2] = mk(1'b1, 4'd0, 1'b1);
        tbl[3] = mk(1'b0, 4'd0, 1'b1);
        tbl[4] = mk(1'b0, 4'd0, 1'b1);
        tbl[5] = mk(1'b0, 4'd1, 1'b1);
        tbl[6] = mk(1'b0, 4'd1, 1'b1);
        tbl[7] = mk(1'b0, 4'd1, 1'b1);
        tbl[8] = mk(1'b0, 4'd1, 1'b1);
        tbl[9] = mk(1'b0, 4'd2, 1'b1);

        model_reset();
        #2;
        check_reset_outputs("reset_init");
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int r = 0; r < 10; r++) begin
            start = tbl[r].start;
            stop  = tbl[r].stop;
            clear = tbl[r].clear;
            up    = tbl[r].up;
            step();
            chk($sformatf("vec%0d.ones", r),    int'(ifa.ones),    int'(tbl[r].e_ones));
            chk($sformatf("vec%0d.tens", r),    int'(ifa.tens),    int'(tbl[r].e_tens));
            chk($sformatf("vec%0d.running", r), int'(ifa.running), int'(tbl[r].e_run));
            chk($sformatf("vec%0d.tc", r),      int'(ifa.tc),      int'(tbl[r].e_tc));
        end

        // 09 -> 10 carry, leading-zero blank drops
        wait_count(9, 100);
        repeat (DIV_A - 1) step();
        chk("carry.pre_blank", int'(ifa.blank_tens), 1);
        step();
        chk("carry.ones", int'(ifa.ones), 0);
        chk("carry.tens", int'(ifa.tens), 1);
        chk("carry.blank", int'(ifa.blank_tens), 0);

        // terminal count both directions and wraps
        up    = 1'b0;
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("tc.down_at_00", int'(ifa.tc), 1);
        repeat (DIV_A) step();
        chk("wrap_down.ones", int'(ifa.ones), 9);
        chk("wrap_down.tens", int'(ifa.tens), 9);
        up = 1'b1;
        #1;
        chk("tc.up_at_99", int'(ifa.tc), 1);
        repeat (DIV_A) step();
        chk("wrap_up.ones", int'(ifa.ones), 0);
        chk("wrap_up.tens", int'(ifa.tens), 0);
        chk("wrap_up.tc", int'(ifa.tc), 0);
        up = 1'b0;
        #1;
        chk("tc.down_at_00_again", int'(ifa.tc), 1);

        // clear lands on the same edge as a tick at 37
        up = 1'b1;
        wait_count(37, 400);
        repeat (DIV_A - 1) step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clear_tick.ones", int'(ifa.ones), 0);
        chk("clear_tick.tens", int'(ifa.tens), 0);
        chk("clear_tick.running", int'(ifa.running), 1);

        // start and stop edges together in RUN, then start held high
        start = 1'b1;
        stop  = 1'b1;
        step();
        chk("both_edges.running", int'(ifa.running), 0);
        frozen = m_cnt[0];
        stop = 1'b0;
        repeat (20) step();
        chk("held_start.running", int'(ifa.running), 0);
        chk("held_start.frozen", int'(ifa.tens) * 10 + int'(ifa.ones), frozen);

        // start held through reset must not restart the run
        rst = 1'b1;
        #1;
        check_reset_outputs("reset_held_start");
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) step();
        chk("post_reset.held_start", int'(ifa.running), 0);
        start = 1'b0;
        step();
        start = 1'b1;
        step();
        chk("post_reset.fresh_edge", int'(ifa.running), 1);
        start = 1'b0;

        // randomized traffic
        for (int c = 0; c < 1500; c++) begin
            start = ($urandom_range(0, 7) == 0);
            stop  = ($urandom_range(0, 39) == 0);
            clear = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 29) == 0) up = ~up;
            step();
        end

        // asynchronous reset between edges at count 45
        start = 1'b0;
        stop  = 1'b0;
        clear = 1'b0;
        up    = 1'b1;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        clear = 1'b1;
        step();
        clear = 1'b0;
        wait_count(45, 400);
        chk("pre_async.running", int'(ifa.running), 1);
        #3;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_all();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
